// File: rtl/sub6bit_serial_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding, default width,
// and the bit-counter width rule.
package sub6bit_serial_pkg;

    localparam int N_DEF = 6;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // A 1-bit operand still gets a 1-bit counter.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sub6bit_serial_if.sv
// Request/result bundle between a requester and the serial subtractor.
interface sub6bit_serial_if #(
    parameter int N = sub6bit_serial_pkg::N_DEF
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         busy;
    logic         done;

    modport master (
        output start, a, b, bin,
        input  diff, bout, ovf, busy, done
    );

    modport slave (
        input  start, a, b, bin,
        output diff, bout, ovf, busy, done
    );
endinterface

// File: rtl/sub6bit_serial_fsub1.sv
// One-bit full subtractor used as the serial datapath slice.
module fsub1 (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/sub6bit_serial.sv
// Bit-serial N-bit subtractor: one bit per cycle LSB first, results are
// published only when the last bit completes (requires N >= 2).
module sub6bit_serial
    import sub6bit_serial_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    sub6bit_serial_if.slave  bus
);
    localparam int CW = cnt_w(N);

    state_t        state, nstate;
    logic [CW-1:0] cnt;
    logic [N-1:0]  sa, sb, sd;
    logic          borrow;
    logic          amsb, bmsb;
    logic          load, step, last;
    logic          d_bit, bo_bit;
    logic [N-1:0]  diff_q;
    logic          bout_q, ovf_q;

    fsub1 u_fsub1 (
        .x  (sa[0]),
        .y  (sb[0]),
        .bi (borrow),
        .d  (d_bit),
        .bo (bo_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        load   = 1'b0;
        step   = 1'b0;
        last   = (cnt == CW'(N - 1));
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load   = 1'b1;
                    nstate = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) nstate = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    load   = 1'b1;
                    nstate = RUN;
                end else begin
                    nstate = IDLE;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    // The working shift register sd is separate from diff_q so the visible
    // result never shows partial bits while a new operation runs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa     <= '0;
            sb     <= '0;
            sd     <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            amsb   <= 1'b0;
            bmsb   <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (load) begin
            sa     <= bus.a;
            sb     <= bus.b;
            borrow <= bus.bin;
            cnt    <= '0;
            amsb   <= bus.a[N-1];
            bmsb   <= bus.b[N-1];
        end else if (step) begin
            sa     <= sa >> 1;
            sb     <= sb >> 1;
            borrow <= bo_bit;
            sd     <= {d_bit, sd[N-1:1]};
            if (last) begin
                diff_q <= {d_bit, sd[N-1:1]};
                bout_q <= bo_bit;
                ovf_q  <= (amsb != bmsb) && (d_bit != amsb);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);

endmodule

// File: tb/tb_sub6bit_serial.sv
// Directed checks of the serial subtractor: reset, operand vectors, start
// while running, back-to-back requests and reset abort.
module tb_sub6bit_serial;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sub6bit_serial_if #(.N(6)) bus();

    sub6bit_serial #(.N(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b1;
        bus.a = 6'd13; bus.b = 6'd5; bus.bin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.diff !== 6'd0) begin bad++; $display("FAIL reset_diff got=%0d want=0", bus.diff); end
        total++; if (bus.bout !== 1'b0) begin bad++; $display("FAIL reset_bout got=%b want=0", bus.bout); end
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        rst_n = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy got=%b want=0", bus.busy); end
    endtask

    // Issues one request in the current cycle (cycle 0) and scrambles the
    // operands right after acceptance; result must reflect the originals.
    task automatic test_vector(input string nm, input logic [5:0] va, input logic [5:0] vb,
                               input logic vbin, input logic [5:0] ed, input logic eb,
                               input logic eo);
        int got;
        int nbusy;
        bit both;
        got = -1; nbusy = 0; both = 0;
        bus.a = va; bus.b = vb; bus.bin = vbin; bus.start = 1'b1;
        for (int c = 1; c <= 20 && got < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start = 1'b0;
                bus.a = ~va; bus.b = ~vb; bus.bin = ~vbin;
            end
            if (bus.busy) nbusy++;
            if (bus.busy && bus.done) both = 1'b1;
            if (bus.done) got = c;
        end
        total++; if (got !== 7) begin bad++; $display("FAIL %s latency got=%0d want=7", nm, got); end
        total++; if (nbusy !== 6) begin bad++; $display("FAIL %s busy_cycles got=%0d want=6", nm, nbusy); end
        total++; if (both) begin bad++; $display("FAIL %s busy_and_done got=1 want=0", nm); end
        total++; if (bus.diff !== ed) begin bad++; $display("FAIL %s diff got=%0d want=%0d", nm, bus.diff, ed); end
        total++; if (bus.bout !== eb) begin bad++; $display("FAIL %s bout got=%b want=%b", nm, bus.bout, eb); end
        total++; if (bus.ovf !== eo) begin bad++; $display("FAIL %s ovf got=%b want=%b", nm, bus.ovf, eo); end
        @(negedge clk);
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL %s done_width got=%b want=0", nm, bus.done); end
        total++; if (bus.diff !== ed) begin bad++; $display("FAIL %s diff_hold got=%0d want=%0d", nm, bus.diff, ed); end
    endtask

    task automatic test_ignore_start();
        int first;
        int ndone;
        first = -1; ndone = 0;
        bus.a = 6'd20; bus.b = 6'd4; bus.bin = 1'b0; bus.start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (first < 0) begin
                    first = c;
                    total++; if (bus.diff !== 6'd16) begin bad++; $display("FAIL ignore_diff got=%0d want=16", bus.diff); end
                    total++; if (bus.bout !== 1'b0) begin bad++; $display("FAIL ignore_bout got=%b want=0", bus.bout); end
                end
            end
            if (c == 1) bus.start = 1'b0;
            if (c == 3) begin bus.start = 1'b1; bus.a = 6'd1; bus.b = 6'd2; end
            if (c == 4) bus.start = 1'b0;
        end
        total++; if (first !== 7) begin bad++; $display("FAIL ignore_latency got=%0d want=7", first); end
        total++; if (ndone !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", ndone); end
    endtask

    task automatic test_back_to_back();
        int c1, c2, ndone;
        c1 = -1; c2 = -1; ndone = 0;
        bus.a = 6'd9; bus.b = 6'd3; bus.bin = 1'b0; bus.start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (c1 < 0) begin
                    c1 = c;
                    total++; if (bus.diff !== 6'd6) begin bad++; $display("FAIL b2b_diff1 got=%0d want=6", bus.diff); end
                    total++; if (bus.bout !== 1'b0) begin bad++; $display("FAIL b2b_bout1 got=%b want=0", bus.bout); end
                end else begin
                    c2 = c;
                    total++; if (bus.diff !== 6'd58) begin bad++; $display("FAIL b2b_diff2 got=%0d want=58", bus.diff); end
                    total++; if (bus.bout !== 1'b1) begin bad++; $display("FAIL b2b_bout2 got=%b want=1", bus.bout); end
                end
            end
            if (c == 7) begin bus.a = 6'd3; bus.b = 6'd9; end
            if (c == 8) bus.start = 1'b0;
            if (c == 10) begin
                total++; if (bus.diff !== 6'd6) begin bad++; $display("FAIL b2b_hold got=%0d want=6", bus.diff); end
            end
        end
        total++; if (c1 !== 7) begin bad++; $display("FAIL b2b_cycle1 got=%0d want=7", c1); end
        total++; if (c2 !== 14) begin bad++; $display("FAIL b2b_cycle2 got=%0d want=14", c2); end
        total++; if (ndone !== 2) begin bad++; $display("FAIL b2b_done_count got=%0d want=2", ndone); end
    endtask

    task automatic test_reset_abort();
        int ndone;
        ndone = 0;
        bus.a = 6'd20; bus.b = 6'd4; bus.bin = 1'b0; bus.start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
            if (c == 1) bus.start = 1'b0;
            if (c == 4) rst_n = 1'b0;
            if (c == 5) begin
                total++; if (bus.diff !== 6'd0) begin bad++; $display("FAIL abort_diff got=%0d want=0", bus.diff); end
                total++; if (bus.bout !== 1'b0) begin bad++; $display("FAIL abort_bout got=%b want=0", bus.bout); end
                total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
                rst_n = 1'b1;
            end
        end
        total++; if (ndone !== 0) begin bad++; $display("FAIL abort_done_count got=%0d want=0", ndone); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_vector("v13m5",  6'd13, 6'd5,  1'b0, 6'd8,  1'b0, 1'b0);
        test_vector("v5m13",  6'd5,  6'd13, 1'b0, 6'd56, 1'b1, 1'b0);
        test_vector("v0m0b1", 6'd0,  6'd0,  1'b1, 6'd63, 1'b1, 1'b0);
        test_vector("v32m1",  6'd32, 6'd1,  1'b0, 6'd31, 1'b0, 1'b1);
        test_vector("v63m63b1", 6'd63, 6'd63, 1'b1, 6'd63, 1'b1, 1'b0);
        test_vector("v31m63", 6'd31, 6'd63, 1'b0, 6'd32, 1'b1, 1'b1);
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_vector("v7m7_after_abort", 6'd7, 6'd7, 1'b0, 6'd0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
